// File: rtl/four_bit_rr_arbiter_if.sv
// Handshake bundle between two 4-bit word producers, the round-robin arbiter and one consumer.
// The master modport is the arbiter side; the slave modport is the surrounding environment.
interface four_bit_rr_arbiter_if;
  logic       Req_0;
  logic [3:0] Data_0;
  logic       Ack_0;
  logic       Req_1;
  logic [3:0] Data_1;
  logic       Ack_1;
  logic       Out_Valid;
  logic [3:0] Out_Data;
  logic       Out_Ready;
  logic       Select;

  modport master (
    input  Req_0, Data_0, Req_1, Data_1, Out_Ready,
    output Ack_0, Ack_1, Out_Valid, Out_Data, Select
  );

  modport slave (
    output Req_0, Data_0, Req_1, Data_1, Out_Ready,
    input  Ack_0, Ack_1, Out_Valid, Out_Data, Select
  );
endinterface

// File: rtl/four_bit_rr_arbiter.sv
// Two-requester round-robin arbiter with burst-limited fairness, driving a 4-bit 2x1 mux
// into a single registered valid/ready output slot.
module four_bit_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input logic                   Clock,
  input logic                   Reset,
  four_bit_rr_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  localparam logic [3:0] MaxCount = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic       select_q, select_d;
  logic       last_q, last_d;
  logic [3:0] count_q, count_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_data_q, out_data_d;

  logic       owner, owner_req, other_req;
  logic       slot_free, transfer, win;
  logic [3:0] count_inc, mux_data;

  assign owner     = (state_q == StGrant1);
  assign owner_req = owner ? bus.Req_1 : bus.Req_0;
  assign other_req = owner ? bus.Req_0 : bus.Req_1;
  assign slot_free = !out_valid_q || bus.Out_Ready;
  assign transfer  = (state_q != StIdle) && owner_req && slot_free;
  assign count_inc = count_q + 4'd1;
  // Select tracks the owner in both grant states, so the mux needs no state decode.
  assign mux_data  = select_q ? bus.Data_1 : bus.Data_0;

  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    last_d      = last_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    win         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.Req_0 || bus.Req_1) begin
          win      = (bus.Req_0 && bus.Req_1) ? ~last_q : bus.Req_1;
          state_d  = win ? StGrant1 : StGrant0;
          select_d = win;
          count_d  = 4'd0;
        end
      end
      StGrant0, StGrant1: begin
        if (transfer) begin
          count_d = count_inc;
        end
        // Release on burst exhaustion or withdrawal; the other side gets priority on handover.
        if (!owner_req || (transfer && count_inc == MaxCount)) begin
          last_d  = owner;
          count_d = 4'd0;
          if (other_req) begin
            state_d  = owner ? StGrant0 : StGrant1;
            select_d = ~owner;
          end else if (!owner_req) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
    end else if (out_valid_q && bus.Out_Ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      select_q    <= 1'b0;
      last_q      <= 1'b1;
      count_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      last_q      <= last_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.Ack_0     = transfer && !owner;
  assign bus.Ack_1     = transfer && owner;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Out_Data  = out_data_q;
  assign bus.Select    = select_q;

endmodule

// File: tb/tb_four_bit_rr_arbiter.sv
// Directed bench for four_bit_rr_arbiter: a cycle model of the arbitration rules is checked
// against the DUT every cycle, alongside hand-computed expectations for each scenario.
module tb_four_bit_rr_arbiter;

  localparam int MB = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  four_bit_rr_arbiter_if bus();

  four_bit_rr_arbiter #(.MAX_BURST(MB)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Model state: owner -1 means nobody holds the grant.
  typedef struct {
    int owner;
    int burst;
    int last;
    int sel;
    int ov;
    int od;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t s;
    s.owner = -1;
    s.burst = 0;
    s.last  = 1;
    s.sel   = 0;
    s.ov    = 0;
    s.od    = 0;
    return s;
  endfunction

  function automatic void mstep(input mstate_t s, input int r0, input int r1, input int d0,
                                input int d1, input int rdy, output mstate_t n,
                                output int a0, output int a1);
    int req[2];
    int data[2];
    int o;
    int xfer;
    req[0]  = r0;
    req[1]  = r1;
    data[0] = d0;
    data[1] = d1;
    n    = s;
    a0   = 0;
    a1   = 0;
    xfer = 0;
    if (s.owner < 0) begin
      if (req[0] != 0 && req[1] != 0) n.owner = 1 - s.last;
      else if (req[0] != 0)           n.owner = 0;
      else if (req[1] != 0)           n.owner = 1;
      if (n.owner >= 0) begin
        n.sel   = n.owner;
        n.burst = 0;
      end
    end else begin
      o    = s.owner;
      xfer = (req[o] != 0 && (s.ov == 0 || rdy != 0)) ? 1 : 0;
      if (xfer != 0) begin
        if (o == 0) a0 = 1;
        else        a1 = 1;
        n.ov    = 1;
        n.od    = data[o];
        n.burst = s.burst + 1;
      end
      if (req[o] == 0 || (xfer != 0 && n.burst == MB)) begin
        n.last  = o;
        n.burst = 0;
        if (req[1 - o] != 0) n.owner = 1 - o;
        else if (req[o] != 0) n.owner = o;
        else n.owner = -1;
        if (n.owner >= 0) n.sel = n.owner;
      end
    end
    if (xfer == 0 && s.ov != 0 && rdy != 0) n.ov = 0;
  endfunction

  mstate_t cur;
  mstate_t nxt;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) cur <= mreset();
    else       cur <= nxt;
  end

  always @(negedge Clock) begin : cmp
    mstate_t n;
    int a0, a1;
    mstep(cur, int'(bus.Req_0), int'(bus.Req_1), int'(bus.Data_0), int'(bus.Data_1),
          int'(bus.Out_Ready), n, a0, a1);
    chk("model_ack_0", int'(bus.Ack_0), a0);
    chk("model_ack_1", int'(bus.Ack_1), a1);
    chk("model_out_valid", int'(bus.Out_Valid), cur.ov);
    chk("model_out_data", int'(bus.Out_Data), cur.od);
    chk("model_select", int'(bus.Select), cur.sel);
    nxt <= n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] held;
    bus.Req_0     = 1'b0;
    bus.Req_1     = 1'b0;
    bus.Data_0    = 4'h0;
    bus.Data_1    = 4'h0;
    bus.Out_Ready = 1'b1;
    #1 Reset = 1'b1;
    repeat (2) step();
    chk("reset_out_valid", int'(bus.Out_Valid), 0);
    chk("reset_out_data", int'(bus.Out_Data), 0);
    chk("reset_select", int'(bus.Select), 0);
    Reset = 1'b0;
    step();

    // Single requester: Ack in the 2nd cycle, data one edge later.
    bus.Data_0 = 4'hA;
    bus.Req_0  = 1'b1;
    #1 chk("single_no_ack_idle", int'(bus.Ack_0), 0);
    step();
    chk("single_ack", int'(bus.Ack_0), 1);
    step();
    bus.Req_0 = 1'b0;
    #1;
    chk("single_out_valid", int'(bus.Out_Valid), 1);
    chk("single_out_data", int'(bus.Out_Data), 'hA);
    chk("single_ack_dropped", int'(bus.Ack_0), 0);
    repeat (2) step();

    // Contention, interrupted by reset mid-burst; last owner was 0 so 1 wins this tie.
    bus.Data_0 = 4'h3;
    bus.Data_1 = 4'hC;
    bus.Req_0  = 1'b1;
    bus.Req_1  = 1'b1;
    repeat (3) step();
    chk("pre_reset_valid", int'(bus.Out_Valid), 1);
    chk("pre_reset_select", int'(bus.Select), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_valid", int'(bus.Out_Valid), 0);
    chk("async_reset_data", int'(bus.Out_Data), 0);
    chk("async_reset_select", int'(bus.Select), 0);
    chk("async_reset_ack_0", int'(bus.Ack_0), 0);
    chk("async_reset_ack_1", int'(bus.Ack_1), 0);
    step();
    Reset = 1'b0;
    step();
    chk("tie_after_reset_ack_0", int'(bus.Ack_0), 1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("burst_valid", int'(bus.Out_Valid), 1);
      chk("burst_data", int'(bus.Out_Data), ((i / 4) % 2 == 0) ? 'h3 : 'hC);
      chk("burst_select", int'(bus.Select), ((i + 1) / 4) % 2);
    end

    // Backpressure with requester 1 owning a fresh burst.
    bus.Out_Ready = 1'b0;
    #1;
    held = bus.Out_Data;
    chk("bp_ack_1_held", int'(bus.Ack_1), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ack_0", int'(bus.Ack_0), 0);
      chk("bp_ack_1", int'(bus.Ack_1), 0);
      chk("bp_data_stable", int'(bus.Out_Data), int'(held));
    end
    bus.Out_Ready = 1'b1;
    #1 chk("bp_resume_ack", int'(bus.Ack_1), 1);
    step();
    chk("bp_resume_data", int'(bus.Out_Data), 'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_burst_rest", int'(bus.Out_Data), 'hC);
    end
    step();
    chk("bp_handover", int'(bus.Out_Data), 'h3);
    bus.Req_0 = 1'b0;
    bus.Req_1 = 1'b0;
    repeat (3) step();

    // Early withdrawal by requester 1 after two transfers.
    bus.Data_1 = 4'h5;
    bus.Req_1  = 1'b1;
    step();
    chk("wd_ack_1", int'(bus.Ack_1), 1);
    repeat (2) step();
    chk("wd_data", int'(bus.Out_Data), 'h5);
    bus.Req_1 = 1'b0;
    #1 chk("wd_no_ack", int'(bus.Ack_1), 0);
    step();
    bus.Data_0 = 4'h6;
    bus.Data_1 = 4'h9;
    bus.Req_0  = 1'b1;
    bus.Req_1  = 1'b1;
    #1;
    chk("wd_idle_ack_0", int'(bus.Ack_0), 0);
    chk("wd_idle_ack_1", int'(bus.Ack_1), 0);
    step();
    chk("wd_tie_ack_0", int'(bus.Ack_0), 1);
    chk("wd_tie_ack_1", int'(bus.Ack_1), 0);
    chk("wd_tie_select", int'(bus.Select), 0);
    step();
    chk("wd_tie_data", int'(bus.Out_Data), 'h6);
    bus.Req_0 = 1'b0;
    bus.Req_1 = 1'b0;
    repeat (3) step();

    // Exhaustive data sweep: each side is served once per pair, holding its word until Ack.
    for (int k = 0; k < 256; k++) begin
      int pending;
      int got0;
      int got1;
      logic [3:0] a;
      logic [3:0] b;
      a          = 4'(k >> 4);
      b          = 4'(k & 15);
      bus.Data_0 = a;
      bus.Data_1 = b;
      bus.Req_0  = 1'b1;
      bus.Req_1  = 1'b1;
      pending    = 2;
      for (int c = 0; c < 12 && pending > 0; c++) begin
        #1;
        got0 = int'(bus.Ack_0);
        got1 = int'(bus.Ack_1);
        step();
        if (got0 != 0) begin
          chk("sweep_data_0", int'(bus.Out_Data), int'(a));
          bus.Req_0 = 1'b0;
          pending--;
        end
        if (got1 != 0) begin
          chk("sweep_data_1", int'(bus.Out_Data), int'(b));
          bus.Req_1 = 1'b0;
          pending--;
        end
      end
      if (pending != 0) chk("sweep_timeout_pending", pending, 0);
    end
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_bit_rr_arbiter.md
# four_bit_rr_arbiter

Round-robin arbiter that shares the 4-bit 2x1 mux datapath between two requesters and feeds one registered output channel. Each requester presents a 4-bit word under a request/acknowledge handshake. The arbiter drives the mux `Select`, applies burst-limited fairness, and loads the selected word into an output register with a valid/ready handshake. It sits between two word producers and a single downstream 4-bit consumer.

## Interface
- `MAX_BURST`, default 4: maximum consecutive transfers per grant while the other side is requesting. Legal range 1..15.
- `Clock`  input  1: sole clock; all state updates on the rising edge.
- `Reset`  input  1: asynchronous, active-high; clears all state immediately.
- `Req_0`  input  1: requester 0 has a word; held high with stable `Data_0` until `Ack_0`.
- `Data_0`  input  4: requester 0 word.
- `Ack_0`  output  1: combinational one-cycle pulse; `Data_0` is captured at the next edge.
- `Req_1`  input  1: same as `Req_0`, for requester 1.
- `Data_1`  input  4: same as `Data_0`, for requester 1.
- `Ack_1`  output  1: same as `Ack_0`, for requester 1.
- `Out_Valid`  output  1: registered; `Out_Data` is valid.
- `Out_Data`  output  4: registered output word.
- `Out_Ready`  input  1: consumer accepts the word when `Out_Valid` and `Out_Ready` are both high at an edge.
- `Select`  output  1: registered current owner; drives the 2x1 mux (0 selects `Data_0`, 1 selects `Data_1`).

## Operation
- State machine has three states: IDLE, GRANT_0 and GRANT_1. A 4-bit burst counter `Count` tracks transfers in the current grant. A 1-bit `Last` register records the most recently released owner.
- **Reset:** state IDLE, `Select`=0, `Last`=1 (so requester 0 wins the first tie), `Count`=0, `Out_Valid`=0, `Out_Data`=0. `Ack_0` and `Ack_1` are 0 throughout reset.
- **IDLE:**
  - If only `Req_x` is high, go to GRANT_x.
  - If both are high, go to GRANT of the side that is not `Last`.
  - On entering a grant, set `Select`=x and `Count`=0.
  - With no requests, stay in IDLE; `Select` holds its value.
  - No Ack is issued in IDLE.
- **Output slot free** means `Out_Valid`=0, or `Out_Valid`=1 and `Out_Ready`=1.
- **GRANT_x transfer:** occurs when `Req_x`=1 and the output slot is free.
  - `Ack_x`=1 in that cycle.
  - At the edge, `Out_Data` is loaded with the mux output (`Data_x`), `Out_Valid` is set to 1, and `Count` increments.
  - `Ack` of the non-owner is always 0.
- **Release:** GRANT_x releases at the edge when either condition holds:
  - (a) a transfer makes `Count` reach `MAX_BURST`, or
  - (b) `Req_x`=0.
- **On release:** `Last` is set to x, `Count` is cleared, and the next state is chosen in this order:
  - GRANT of the other side if its Req is high;
  - otherwise GRANT_x again if `Req_x` is still high (burst restart, no contention);
  - otherwise IDLE.
- **Output drain:** if `Out_Valid`=1, `Out_Ready`=1 and no transfer loads this cycle, `Out_Valid` goes to 0 at the edge and `Out_Data` holds.
- **Backpressure:** with `Out_Valid`=1 and `Out_Ready`=0, no Ack is issued and `Out_Data` is stable. Grant and `Count` hold unless `Req_x` drops.
- **Requester protocol:** dropping Req before Ack is legal and withdraws the word; no transfer occurs.
- **Reset mid-operation:** an in-flight `Out_Data` is discarded and no Ack is pending after reset.

## Timing
- Latency: `Req_x` rising in IDLE at cycle N gives the grant at edge N+1, `Ack_x` during N+1, and `Out_Valid`=1 after edge N+2.
- Throughput: 1 word/cycle while the owner keeps requesting and `Out_Ready`=1.
- Handover costs zero idle cycles. The last transfer of x and the state change to the other side happen at the same edge, so the other side can be acknowledged in the next cycle.
- `Ack_x` is a combinational function of state, `Req_x`, `Out_Valid` and `Out_Ready`. There is no combinational path from `Data_x` to any output.
- Reset assertion forces all outputs to their reset values immediately, independent of `Clock`.

## Test plan
- **Reset values:** assert `Reset` mid-burst with `Out_Valid`=1. Required: `Out_Valid`=0, `Out_Data`=0, `Select`=0 and Acks=0 immediately; after release, the first tie is granted to requester 0.
- **Single requester:** `Req_0`=1 with `Data_0`=4'hA, `Out_Ready`=1. Required: `Ack_0` in the 2nd cycle after the request and `Out_Data`=4'hA with `Out_Valid`=1 one edge later.
- **Contention with `MAX_BURST`=4:** both Req held, `Data_0`=4'h3, `Data_1`=4'hC, `Out_Ready`=1. Required: `Out_Data` sequence 3,3,3,3,C,C,C,C,3,… with no gap cycles and `Select` toggling every 4 transfers.
- **Backpressure:** `Out_Ready`=0 for 5 cycles with a word pending. Required: `Out_Data` stable, no Ack, `Count` unchanged; when `Out_Ready` returns to 1, a transfer occurs that cycle.
- **Early withdrawal:** `Req_1` drops after 2 of 4 transfers while `Req_0`=0. Required: GRANT_1 goes to IDLE with `Last`=1; a subsequent tie is granted to requester 0.
- **Exhaustive data path:** sweep all 16×16 `Data_0`/`Data_1` combinations with alternating grants. Required: every `Out_Data` equals the acknowledged requester's word.
